pingpong_ram_sched: RTL and testbench

//  Master side of ram_manage_if. Schedules the two frame RAMs (ram0/ram1) of the transpose path as a ping-pong pair.

---
 rtl/pingpong_ram_sched_pkg.sv | 24 ++
 rtl/pp_side_fsm.sv | 95 +++++++++
 rtl/pingpong_ram_sched.sv | 150 +++++++++++++++
 tb/tb_pingpong_ram_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_ram_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_pkg
//  Description : Shared types for the ping-pong frame RAM scheduler.
//                bank_st_t tracks the occupancy of one frame RAM.
//                side_st_t is the state of the write-side or read-side FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package pingpong_pkg;

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_WRITING = 2'd1,
        B_FULL    = 2'd2,
        B_READING = 2'd3
    } bank_st_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } side_st_t;

endpackage
`default_nettype wire

// File: rtl/pp_side_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pp_side_fsm
//  Description : One side (write or read) of the ping-pong scheduler.
//                IDLE -> BUSY when start_ok, emitting a registered 1-cycle
//                cmd pulse. BUSY -> IDLE on finish (ptr toggles) or when the
//                watchdog expires (ptr toggles only if TOGGLE_ON_TIMEOUT).
//  Ports       : clk, rst      - clock, async active-high reset
//                start_ok      - all start conditions met (en, request, bank)
//                finish        - qualified finish pulse for the selected bank
//                cmd           - 1-cycle command pulse
//                busy          - side is in BUSY
//                timeout       - 1-cycle pulse, watchdog expired this cycle
//                ptr           - currently selected bank
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_side_fsm
    import pingpong_pkg::*;
#(
    parameter int TIMEOUT           = 64,
    parameter bit TOGGLE_ON_TIMEOUT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic start_ok,
    input  logic finish,
    output logic cmd,
    output logic busy,
    output logic timeout,
    output logic ptr
);

    localparam int              WD_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] c_wd_limit = WD_W'(TIMEOUT);

    side_st_t        r_state;
    side_st_t        w_state_nxt;
    logic            r_cmd;
    logic            r_ptr;
    logic [WD_W-1:0] r_wd;
    logic            w_start;
    logic            w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_ok) begin
                    w_state_nxt = S_BUSY;
                    w_start     = 1'b1;
                end
            end
            S_BUSY: begin
                // A finish arriving on the expiry cycle still counts as done.
                if (finish) begin
                    w_state_nxt = S_IDLE;
                end else if ((TIMEOUT > 0) && (r_wd == c_wd_limit)) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cmd   <= 1'b0;
            r_ptr   <= 1'b0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_start;
            // Watchdog counts consecutive BUSY cycles; cleared whenever idle.
            if ((r_state == S_BUSY) && (w_state_nxt == S_BUSY)) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
            if (((r_state == S_BUSY) && finish) || (w_timeout && TOGGLE_ON_TIMEOUT)) begin
                r_ptr <= ~r_ptr;
            end
        end
    end

    assign cmd     = r_cmd;
    assign busy    = (r_state == S_BUSY);
    assign timeout = w_timeout;
    assign ptr     = r_ptr;

endmodule
`default_nettype wire

// File: rtl/pingpong_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_ram_sched
//  Description : Master side of ram_manage_if. Schedules two frame RAMs as a
//                ping-pong pair: issues wr/rd command pulses, selects the bank
//                for each side and tracks per-bank occupancy so a frame is
//                never overwritten before read nor read before complete.
//  Ports       : clk, rst                 - clock, async active-high reset
//                en                       - allow new commands
//                frame_req, rd_ready      - upstream / downstream levels
//                wr_command, wr_ram_number- write pulse and selected bank
//                rd_command, rd_ram_number- read pulse and selected bank
//                wr_finish_0/1, rd_finish_0/1 - done pulses per bank
//                bank_full                - bank holds complete unread frame
//                wr_stall                 - writer blocked by occupied bank
//                frames_wr, frames_rd     - completed frame counters (wrap)
//                err_timeout, err_protocol- sticky errors, err_clr clears
//  Revision    : 1.0 - initial release
// ============================================================================
module pingpong_ram_sched
    import pingpong_pkg::*;
#(
    parameter int ROW       = 64,
    parameter int CLO       = 2400,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 2 * ROW * CLO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 frame_req,
    input  logic                 rd_ready,
    output logic                 wr_command,
    output logic                 wr_ram_number,
    output logic                 rd_command,
    output logic                 rd_ram_number,
    input  logic                 wr_finish_0,
    input  logic                 wr_finish_1,
    input  logic                 rd_finish_0,
    input  logic                 rd_finish_1,
    output logic [1:0]           bank_full,
    output logic                 wr_stall,
    output logic [CNT_WIDTH-1:0] frames_wr,
    output logic [CNT_WIDTH-1:0] frames_rd,
    output logic                 err_timeout,
    output logic                 err_protocol,
    input  logic                 err_clr
);

    bank_st_t             r_bank [0:1];
    logic [CNT_WIDTH-1:0] r_frames_wr;
    logic [CNT_WIDTH-1:0] r_frames_rd;
    logic                 r_err_timeout;
    logic                 r_err_protocol;

    logic w_wr_busy, w_wr_ptr, w_wr_to, w_wr_start, w_wr_fin;
    logic w_rd_busy, w_rd_ptr, w_rd_to, w_rd_start, w_rd_fin;
    logic w_wr_ok0, w_wr_ok1, w_rd_ok0, w_rd_ok1;
    logic w_proto_err;

    // A finish pulse is accepted only for the bank the busy side targets.
    assign w_wr_ok0 = w_wr_busy && !w_wr_ptr && (r_bank[0] == B_WRITING);
    assign w_wr_ok1 = w_wr_busy &&  w_wr_ptr && (r_bank[1] == B_WRITING);
    assign w_rd_ok0 = w_rd_busy && !w_rd_ptr && (r_bank[0] == B_READING);
    assign w_rd_ok1 = w_rd_busy &&  w_rd_ptr && (r_bank[1] == B_READING);

    assign w_wr_fin = (wr_finish_0 && w_wr_ok0) || (wr_finish_1 && w_wr_ok1);
    assign w_rd_fin = (rd_finish_0 && w_rd_ok0) || (rd_finish_1 && w_rd_ok1);

    assign w_proto_err = (wr_finish_0 && !w_wr_ok0) || (wr_finish_1 && !w_wr_ok1) ||
                         (rd_finish_0 && !w_rd_ok0) || (rd_finish_1 && !w_rd_ok1);

    assign w_wr_start = en && frame_req && !w_wr_busy && (r_bank[w_wr_ptr] == B_EMPTY);
    assign w_rd_start = en && rd_ready  && !w_rd_busy && (r_bank[w_rd_ptr] == B_FULL);

    pp_side_fsm #(
        .TIMEOUT           (TIMEOUT),
        .TOGGLE_ON_TIMEOUT (1'b0)
    ) u_wr_side (
        .clk      (clk),
        .rst      (rst),
        .start_ok (w_wr_start),
        .finish   (w_wr_fin),
        .cmd      (wr_command),
        .busy     (w_wr_busy),
        .timeout  (w_wr_to),
        .ptr      (w_wr_ptr)
    );

    // A timed-out read drops its frame and moves on to the other bank.
    pp_side_fsm #(
        .TIMEOUT           (TIMEOUT),
        .TOGGLE_ON_TIMEOUT (1'b1)
    ) u_rd_side (
        .clk      (clk),
        .rst      (rst),
        .start_ok (w_rd_start),
        .finish   (w_rd_fin),
        .cmd      (rd_command),
        .busy     (w_rd_busy),
        .timeout  (w_rd_to),
        .ptr      (w_rd_ptr)
    );

    // The write and read sides always touch banks in different states, so
    // the per-bank updates below never target the same bank in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank[0]      <= B_EMPTY;
            r_bank[1]      <= B_EMPTY;
            r_frames_wr    <= '0;
            r_frames_rd    <= '0;
            r_err_timeout  <= 1'b0;
            r_err_protocol <= 1'b0;
        end else begin
            if (w_wr_start) r_bank[w_wr_ptr] <= B_WRITING;
            if (w_wr_fin) begin
                r_bank[w_wr_ptr] <= B_FULL;
                r_frames_wr      <= r_frames_wr + 1'b1;
            end
            if (w_wr_to) r_bank[w_wr_ptr] <= B_EMPTY;

            if (w_rd_start) r_bank[w_rd_ptr] <= B_READING;
            if (w_rd_fin) begin
                r_bank[w_rd_ptr] <= B_EMPTY;
                r_frames_rd      <= r_frames_rd + 1'b1;
            end
            if (w_rd_to) r_bank[w_rd_ptr] <= B_EMPTY;

            if (err_clr) begin
                r_err_timeout  <= 1'b0;
                r_err_protocol <= 1'b0;
            end else begin
                if (w_wr_to || w_rd_to) r_err_timeout  <= 1'b1;
                if (w_proto_err)        r_err_protocol <= 1'b1;
            end
        end
    end

    assign wr_ram_number = w_wr_ptr;
    assign rd_ram_number = w_rd_ptr;
    assign bank_full     = {(r_bank[1] == B_FULL), (r_bank[0] == B_FULL)};
    assign wr_stall      = frame_req && en && !w_wr_busy && (r_bank[w_wr_ptr] != B_EMPTY);
    assign frames_wr     = r_frames_wr;
    assign frames_rd     = r_frames_rd;
    assign err_timeout   = r_err_timeout;
    assign err_protocol  = r_err_protocol;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pingpong_ram_sched
//  Description : Self-checking bench for pingpong_ram_sched (ROW=4, CLO=4,
//                TIMEOUT=64). A vector table covers single-step behaviour;
//                hand-written sequences cover multi-cycle corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_ram_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, frame_req = 1'b0, rd_ready = 1'b0, err_clr = 1'b0;
    logic        wr_finish_0 = 1'b0, wr_finish_1 = 1'b0;
    logic        rd_finish_0 = 1'b0, rd_finish_1 = 1'b0;
    logic        wr_command, wr_ram_number, rd_command, rd_ram_number;
    logic [1:0]  bank_full;
    logic        wr_stall, err_timeout, err_protocol;
    logic [15:0] frames_wr, frames_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Auto-responder state: finish pulse 16 cycles after each command.
    bit auto_wr = 0, auto_rd = 0;
    int wr_cnt = 0, rd_cnt = 0;
    bit wr_bank = 0, rd_bank = 0;

    pingpong_ram_sched #(
        .ROW(4), .CLO(4), .CNT_WIDTH(16), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .frame_req(frame_req), .rd_ready(rd_ready),
        .wr_command(wr_command), .wr_ram_number(wr_ram_number),
        .rd_command(rd_command), .rd_ram_number(rd_ram_number),
        .wr_finish_0(wr_finish_0), .wr_finish_1(wr_finish_1),
        .rd_finish_0(rd_finish_0), .rd_finish_1(rd_finish_1),
        .bank_full(bank_full), .wr_stall(wr_stall),
        .frames_wr(frames_wr), .frames_rd(frames_rd),
        .err_timeout(err_timeout), .err_protocol(err_protocol), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; returns at posedge+1 with finish pulses updated.
    task automatic cycle();
        @(posedge clk);
        #1;
        wr_finish_0 = 1'b0; wr_finish_1 = 1'b0;
        rd_finish_0 = 1'b0; rd_finish_1 = 1'b0;
        if (auto_wr) begin
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) begin
                    if (wr_bank) wr_finish_1 = 1'b1; else wr_finish_0 = 1'b1;
                end
            end
            if (wr_command) begin wr_cnt = 16; wr_bank = wr_ram_number; end
        end
        if (auto_rd) begin
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    if (rd_bank) rd_finish_1 = 1'b1; else rd_finish_0 = 1'b1;
                end
            end
            if (rd_command) begin rd_cnt = 16; rd_bank = rd_ram_number; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0; frame_req = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
        auto_wr = 0; auto_rd = 0; wr_cnt = 0; rd_cnt = 0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_cmd(input bit rd, input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            cycle();
            if ((rd && rd_command) || (!rd && wr_command)) begin
                seen = 1;
                break;
            end
        end
    endtask

    // in : {en, frame_req, rd_ready, wf0, wf1, rf0, rf1, err_clr}
    // out: {wr_cmd, wr_num, rd_cmd, rd_num, full[1], full[0], wr_stall, err_proto}
    typedef struct {
        logic [7:0] in;
        logic [7:0] exp;
        int         fw;
        int         frd;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic [7:0] in, input logic [7:0] exp, input int fw, input int frd);
        vec_t v;
        v.in = in; v.exp = exp; v.fw = fw; v.frd = frd;
        return v;
    endfunction

    initial begin
        bit         seen;
        bit         exp_wb, exp_rb, overlap, bad;
        int         n_w, n_r, t_fr, t_wc, k;
        logic [7:0] outs;

        tbl[0]  = mk(8'b1001_0000, 8'b0000_0001, 0, 0); // wf0 with writer idle
        tbl[1]  = mk(8'b1000_0001, 8'b0000_0000, 0, 0); // clear
        tbl[2]  = mk(8'b1100_0000, 8'b1000_0000, 0, 0); // write bank0
        tbl[3]  = mk(8'b1000_0000, 8'b0000_0000, 0, 0);
        tbl[4]  = mk(8'b1000_1000, 8'b0000_0001, 0, 0); // wf1: wrong bank
        tbl[5]  = mk(8'b1000_0001, 8'b0000_0000, 0, 0);
        tbl[6]  = mk(8'b1001_0000, 8'b0100_0100, 1, 0); // bank0 full
        tbl[7]  = mk(8'b1010_0000, 8'b0110_0000, 1, 0); // read bank0
        tbl[8]  = mk(8'b1100_0000, 8'b1100_0000, 1, 0); // write bank1
        tbl[9]  = mk(8'b1000_0010, 8'b0100_0001, 1, 0); // rf1: wrong bank
        tbl[10] = mk(8'b1001_0101, 8'b0101_0000, 1, 1); // rf0 ok, clr beats new err
        tbl[11] = mk(8'b1000_1000, 8'b0001_1000, 2, 1); // bank1 full
        tbl[12] = mk(8'b1100_0000, 8'b1001_1000, 2, 1); // write bank0
        tbl[13] = mk(8'b1101_0000, 8'b0101_1110, 3, 1); // both full -> stall
        tbl[14] = mk(8'b1100_0000, 8'b0101_1110, 3, 1);
        tbl[15] = mk(8'b0110_0000, 8'b0101_1100, 3, 1); // en=0: no read, no stall
        tbl[16] = mk(8'b1110_0000, 8'b0111_0110, 3, 1); // read bank1
        tbl[17] = mk(8'b1100_0010, 8'b0100_0100, 3, 2); // bank1 empty
        tbl[18] = mk(8'b1100_0000, 8'b1100_0100, 3, 2); // write bank1

        // ---------------- reset state ----------------
        do_reset();
        chk("reset_outputs", {wr_command, wr_ram_number, rd_command, rd_ram_number,
                              bank_full, wr_stall, err_timeout, err_protocol}, 9'd0);
        chk("reset_frames_wr", frames_wr, 0);
        chk("reset_frames_rd", frames_rd, 0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 19; i++) begin
            {en, frame_req, rd_ready, wr_finish_0, wr_finish_1,
             rd_finish_0, rd_finish_1, err_clr} = tbl[i].in;
            cycle();
            outs = {wr_command, wr_ram_number, rd_command, rd_ram_number,
                    bank_full, wr_stall, err_protocol};
            chk($sformatf("vec%0d_outs", i), outs, tbl[i].exp);
            chk($sformatf("vec%0d_frames_wr", i), frames_wr, tbl[i].fw);
            chk($sformatf("vec%0d_frames_rd", i), frames_rd, tbl[i].frd);
        end
        {en, frame_req, rd_ready, wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1, err_clr} = 8'd0;

        // ---------------- streaming 10 frames ----------------
        do_reset();
        en = 1; frame_req = 1; rd_ready = 1; auto_wr = 1; auto_rd = 1;
        exp_wb = 0; exp_rb = 0; overlap = 0; n_w = 0; n_r = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cycle();
            if (wr_command) begin
                chk($sformatf("s1_wr_bank%0d", n_w), wr_ram_number, exp_wb);
                exp_wb = ~exp_wb; n_w++;
                if (n_w == 10) frame_req = 0;
            end
            if (rd_command) begin
                chk($sformatf("s1_rd_bank%0d", n_r), rd_ram_number, exp_rb);
                if (wr_cnt > 0) overlap = 1;
                exp_rb = ~exp_rb; n_r++;
                if (n_r == 10) rd_ready = 0;
            end
            if (frames_wr == 10 && frames_rd == 10) break;
        end
        chk("s1_frames_wr", frames_wr, 10);
        chk("s1_frames_rd", frames_rd, 10);
        chk("s1_overlap", overlap, 1);

        // ---------------- both banks full, reader stalled ----------------
        do_reset();
        en = 1; frame_req = 1; rd_ready = 0; auto_wr = 1; auto_rd = 1; n_w = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            cycle();
            if (wr_command) n_w++;
            if (bank_full == 2'b11) break;
        end
        chk("s2_bank_full", bank_full, 2'b11);
        chk("s2_wr_stall", wr_stall, 1);
        for (int cyc = 0; cyc < 10; cyc++) begin
            cycle();
            if (wr_command) n_w++;
        end
        chk("s2_writes_issued", n_w, 2);
        rd_ready = 1;
        wait_cmd(1, 10, seen);
        chk("s2_rd_cmd_seen", seen, 1);
        chk("s2_rd_bank", rd_ram_number, 0);
        t_fr = -1; t_wc = -1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            cycle();
            if (wr_command) begin t_wc = cyc; break; end
            if (frames_rd == 1 && t_fr < 0) t_fr = cyc;
        end
        chk("s2_wr_bank_after_read", wr_ram_number, 0);
        chk("s2_wr_latency", t_wc - t_fr, 1);

        // ---------------- watchdog ----------------
        do_reset();
        en = 1; frame_req = 1;
        wait_cmd(0, 5, seen);
        chk("s4_wr_cmd_seen", seen, 1);
        frame_req = 0;
        bad = 0; k = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            cycle();
            if (err_timeout) begin k = cyc; break; end
        end
        chk("s4_not_early", (k >= 63), 1);
        chk("s4_err_timeout", err_timeout, 1);
        chk("s4_bank_full", bank_full, 0);
        chk("s4_frames_wr", frames_wr, 0);
        frame_req = 1;
        wait_cmd(0, 5, seen);
        chk("s4_retry_seen", seen, 1);
        chk("s4_retry_bank", wr_ram_number, 0);
        err_clr = 1;
        cycle();
        err_clr = 0;
        chk("s4_err_clr", err_timeout, 0);

        // ---------------- en drop mid-write ----------------
        do_reset();
        en = 1; frame_req = 1; rd_ready = 1; auto_wr = 1; auto_rd = 1;
        wait_cmd(0, 5, seen);
        chk("s5_wr_cmd_seen", seen, 1);
        en = 0; bad = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            cycle();
            if (wr_command || rd_command) bad = 1;
        end
        chk("s5_no_new_cmd", bad, 0);
        chk("s5_bank_full", bank_full, 2'b01);
        chk("s5_frames_wr", frames_wr, 1);
        en = 1;
        wait_cmd(1, 5, seen);
        chk("s5_rd_cmd_seen", seen, 1);
        chk("s5_rd_bank", rd_ram_number, 0);

        // ---------------- reset mid-read ----------------
        cycle(); cycle(); cycle();
        #2;
        rst = 1;
        #1;
        chk("s6_outputs_zero", {wr_command, wr_ram_number, rd_command, rd_ram_number,
                                bank_full, wr_stall, err_timeout, err_protocol}, 9'd0);
        chk("s6_frames_wr_zero", frames_wr, 0);
        auto_wr = 0; auto_rd = 0; wr_cnt = 0; rd_cnt = 0;
        cycle();
        rst = 0;
        en = 1; frame_req = 1; rd_ready = 0;
        wait_cmd(0, 5, seen);
        chk("s6_wr_cmd_seen", seen, 1);
        chk("s6_wr_bank", wr_ram_number, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
